// File: rtl/tb_readout_pkg.sv
// Shared types and helpers for the trace-buffer readout serializer.
// Entries go out as a flag byte followed by the lane bytes.
package tb_readout_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_SEND,
        S_GAP
    } state_t;

    localparam int        BYTE_W   = 8;
    localparam logic [6:0] FLAG_PAD = 7'b0;

    function automatic int bytes_per_entry(input int n, input int data_width);
        return 1 + (n * data_width) / BYTE_W;
    endfunction

    function automatic logic [7:0] flag_byte(input logic flag);
        return {FLAG_PAD, flag};
    endfunction

endpackage

// File: rtl/tb_readout_serializer_entry_shifter.sv
// Holds one serialized trace entry and shifts it out a byte at a time,
// flag byte first, then each lane least-significant byte first.
module entry_shifter
    import tb_readout_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_en,
    input  logic                       shift_en,
    input  logic                       flag,
    input  logic [N-1:0][DATA_WIDTH-1:0] vector,
    output logic [7:0]                 byte_out
);

    localparam int SHIFT_W = BYTE_W * bytes_per_entry(N, DATA_WIDTH);

    logic [SHIFT_W-1:0] shift_reg;

    // Lane 0 sits just above the flag byte, so a plain right shift yields the wire order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else if (load_en) begin
            shift_reg <= {vector, flag_byte(flag)};
        end else if (shift_en) begin
            shift_reg <= shift_reg >> BYTE_W;
        end
    end

    assign byte_out = shift_reg[7:0];

endmodule

// File: rtl/tb_readout_serializer.sv
// Dumps every trace buffer entry, oldest first, to the UART byte interface
// once tracing has stopped.
//
// state | meaning
// IDLE  | waiting for start; pointer latched on accept
// READ  | read address presented, waiting one cycle for buffer data
// LOAD  | capture {flag, vector} into the shifter
// SEND  | wait for UART idle, then strobe the current byte
// GAP   | dead cycle for tx_busy to rise; choose next byte/entry/finish
module tb_readout_serializer
    import tb_readout_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TB_SIZE    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(TB_SIZE)-1:0]   tb_ptr_in,
    output logic [$clog2(TB_SIZE)-1:0]   tb_read_address,
    input  logic [N-1:0][DATA_WIDTH-1:0] vector_in,
    input  logic                         compression_flag_in,
    output logic [7:0]                   tx_data,
    output logic                         new_tx_data,
    input  logic                         tx_busy,
    output logic                         busy,
    output logic                         done
);

    localparam int AW        = $clog2(TB_SIZE);
    localparam int ECW       = AW + 1;
    localparam int BPE       = bytes_per_entry(N, DATA_WIDTH);
    localparam int BCW       = $clog2(BPE);
    localparam logic [ECW-1:0] ENTRY_LAST = ECW'(TB_SIZE - 1);
    localparam logic [BCW-1:0] BYTE_LAST  = BCW'(BPE - 1);

    if (DATA_WIDTH % 8 != 0) begin : g_dw_check
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (TB_SIZE < 2 || (TB_SIZE & (TB_SIZE - 1)) != 0) begin : g_size_check
        $error("TB_SIZE must be a power of two");
    end

    state_t          state;
    logic [ECW-1:0]  entry_cnt;
    logic [BCW-1:0]  byte_cnt;
    logic [7:0]      byte_out;
    logic            load_en;
    logic            shift_en;

    assign load_en  = (state == S_LOAD);
    assign shift_en = (state == S_SEND) && !tx_busy;

    entry_shifter #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (load_en),
        .shift_en (shift_en),
        .flag     (compression_flag_in),
        .vector   (vector_in),
        .byte_out (byte_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            tb_read_address <= '0;
            entry_cnt       <= '0;
            byte_cnt        <= '0;
            tx_data         <= '0;
            new_tx_data     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            new_tx_data <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tb_read_address <= tb_ptr_in;
                        entry_cnt       <= '0;
                        busy            <= 1'b1;
                        state           <= S_READ;
                    end
                end
                S_READ: state <= S_LOAD;
                S_LOAD: begin
                    byte_cnt <= '0;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_data     <= byte_out;
                        new_tx_data <= 1'b1;
                        state       <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (byte_cnt != BYTE_LAST) begin
                        byte_cnt <= byte_cnt + BCW'(1);
                        state    <= S_SEND;
                    end else if (entry_cnt != ENTRY_LAST) begin
                        // Pointer wraps naturally at the buffer depth.
                        entry_cnt       <= entry_cnt + ECW'(1);
                        tb_read_address <= tb_read_address + AW'(1);
                        state           <= S_READ;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
